// File: rtl/leitor_velocidade_if.sv
// Segment-display speed reader bus: raw segment input, consumer ready, and the presented speed word.
// master = the reader block, slave = the consumer that drives seg_in/out_ready and takes the word.
interface leitor_velocidade_if;
  logic [7:0] seg_in;
  logic       out_ready;
  logic       chave1;
  logic       chave2;
  logic [3:0] vel_kmh;
  logic       vel_valid;
  logic       erro;

  modport master (
    input  seg_in,
    input  out_ready,
    output chave1,
    output chave2,
    output vel_kmh,
    output vel_valid,
    output erro
  );

  modport slave (
    output seg_in,
    output out_ready,
    input  chave1,
    input  chave2,
    input  vel_kmh,
    input  vel_valid,
    input  erro
  );
endinterface

// File: rtl/leitor_velocidade.sv
// Decodes a debounced 7-segment speed glyph; vel_valid rises ESTAVEL_CICLOS+1 edges after a new glyph lands.
// The word is held until out_ready; glyph changes seen while a word is pending wait for the next handshake.
module leitor_velocidade #(
  parameter int ESTAVEL_CICLOS = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  leitor_velocidade_if.master bus
);

  localparam logic [3:0] ESTAVEL = 4'(ESTAVEL_CICLOS);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    ENVIA    = 2'd1,
    INVALIDO = 2'd2
  } estado_t;

  logic [7:0] sync1;
  logic [7:0] s;
  logic [3:0] cnt;
  logic       estavel;

  logic       legal;
  logic [1:0] code_dec;
  logic [3:0] vel_dec;

  estado_t    estado;
  logic [7:0] ultimo;
  logic       tem_ultimo;
  logic       difere;

  logic       chave1_q;
  logic       chave2_q;
  logic [3:0] vel_q;
  logic       valid_q;
  logic       erro_q;

  // cnt tracks the run length of s itself: comparing the incoming stage against s
  // makes cnt agree with the value s holds after the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'hFF;
      s     <= 8'hFF;
      cnt   <= 4'd0;
    end else begin
      sync1 <= bus.seg_in;
      s     <= sync1;
      if (sync1 != s) begin
        cnt <= 4'd1;
      end else if (cnt != ESTAVEL) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign estavel = (cnt == ESTAVEL);

  always_comb begin
    legal    = 1'b1;
    code_dec = 2'b00;
    vel_dec  = 4'd0;
    case (s)
      8'b0000_0011: begin code_dec = 2'b00; vel_dec = 4'd0; end
      8'b0010_0101: begin code_dec = 2'b01; vel_dec = 4'd2; end
      8'b1001_1001: begin code_dec = 2'b10; vel_dec = 4'd4; end
      8'b0000_0001: begin code_dec = 2'b11; vel_dec = 4'd8; end
      default:      legal = 1'b0;
    endcase
  end

  assign difere = !tem_ultimo || (s != ultimo);

  // An illegal glyph can never equal the stored one, so a stable illegal s always counts as new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= ESPERA;
      ultimo     <= 8'h00;
      tem_ultimo <= 1'b0;
      chave1_q   <= 1'b0;
      chave2_q   <= 1'b0;
      vel_q      <= 4'd0;
      valid_q    <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      case (estado)
        ESPERA, INVALIDO: begin
          if (estavel && legal) begin
            erro_q <= 1'b0;
            if (difere) begin
              chave1_q   <= code_dec[1];
              chave2_q   <= code_dec[0];
              vel_q      <= vel_dec;
              valid_q    <= 1'b1;
              ultimo     <= s;
              tem_ultimo <= 1'b1;
              estado     <= ENVIA;
            end else begin
              estado <= ESPERA;
            end
          end else if (estavel) begin
            erro_q <= 1'b1;
            estado <= INVALIDO;
          end
        end
        ENVIA: begin
          if (estavel && !legal) begin
            erro_q <= 1'b1;
          end
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            estado  <= ESPERA;
          end
        end
        default: begin
          valid_q <= 1'b0;
          estado  <= ESPERA;
        end
      endcase
    end
  end

  assign bus.chave1    = chave1_q;
  assign bus.chave2    = chave2_q;
  assign bus.vel_kmh   = vel_q;
  assign bus.vel_valid = valid_q;
  assign bus.erro      = erro_q;

endmodule

// File: tb/tb_leitor_velocidade.sv
// Bench for leitor_velocidade: directed vector table, exact-cycle corner sequences,
// and a randomized run compared every cycle against a glyph/run-length reference model.
module tb_leitor_velocidade;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  leitor_velocidade_if bus();

  leitor_velocidade #(.ESTAVEL_CICLOS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_word();
    return {bus.chave1, bus.chave2, bus.vel_kmh, bus.vel_valid, bus.erro};
  endfunction

  // {legal, code[1:0], vel[3:0]}
  function automatic logic [6:0] glyph(input logic [7:0] g);
    case (g)
      8'h03:   return 7'b1_00_0000;
      8'h25:   return 7'b1_01_0010;
      8'h99:   return 7'b1_10_0100;
      8'h01:   return 7'b1_11_1000;
      default: return 7'b0_00_0000;
    endcase
  endfunction

  // Reference model: s is seg_in two samples late; "stable" means the last N values of s agree.
  logic [7:0] m_s1, m_s, m_last;
  logic [7:0] hist[$];
  logic [1:0] m_code;
  logic [3:0] m_vel;
  logic       m_pend, m_err, m_have;
  logic [6:0] m_g;
  bit         m_st;

  function automatic bit is_stable();
    int sz;
    sz = hist.size();
    if (sz < N) return 1'b0;
    for (int i = sz - N; i < sz; i++)
      if (hist[i] != hist[sz-1]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 8'hFF; m_s = 8'hFF; m_last = 8'h00;
      hist.delete();
      m_code = 2'b00; m_vel = 4'd0;
      m_pend = 1'b0; m_err = 1'b0; m_have = 1'b0;
    end else begin
      m_st = is_stable();
      m_g  = glyph(m_s);
      if (m_pend) begin
        if (m_st && !m_g[6]) m_err = 1'b1;
        if (bus.out_ready) m_pend = 1'b0;
      end else if (m_st && m_g[6]) begin
        if (!m_have || m_s != m_last) begin
          m_have = 1'b1; m_last = m_s;
          m_code = m_g[5:4]; m_vel = m_g[3:0];
          m_pend = 1'b1;
        end
        m_err = 1'b0;
      end else if (m_st) begin
        m_err = 1'b1;
      end
      m_s  = m_s1;
      m_s1 = bus.seg_in;
      hist.push_back(m_s);
      if (hist.size() > N) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (mon_en) chk("model_word", {24'd0, dut_word()}, {24'd0, m_code, m_vel, m_pend, m_err});
  end

  typedef struct {
    logic [7:0] seg;
    logic       rdy;
    int         n;
    logic       vld;
    logic [1:0] code;
    logic [3:0] vel;
    logic       erro;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] pool [6];
  int hold;

  initial begin
    tbl.push_back('{8'h03, 1'b1,  8, 1'b0, 2'b00, 4'd0, 1'b0});  // accept 0, handshake at once
    tbl.push_back('{8'h99, 1'b1,  3, 1'b0, 2'b00, 4'd0, 1'b0});  // short glitch to 4
    tbl.push_back('{8'h03, 1'b1,  8, 1'b0, 2'b00, 4'd0, 1'b0});  // back to 0: nothing new
    tbl.push_back('{8'h01, 1'b1,  8, 1'b0, 2'b11, 4'd8, 1'b0});
    tbl.push_back('{8'h00, 1'b1,  8, 1'b0, 2'b11, 4'd8, 1'b1});  // p lit: illegal, speed held
    tbl.push_back('{8'h99, 1'b1,  8, 1'b0, 2'b10, 4'd4, 1'b0});  // leave INVALIDO with 4
    tbl.push_back('{8'h01, 1'b0,  8, 1'b1, 2'b11, 4'd8, 1'b0});  // 8 pending
    tbl.push_back('{8'h99, 1'b0, 10, 1'b1, 2'b11, 4'd8, 1'b0});  // 4 arrives, 8 must hold
    tbl.push_back('{8'h99, 1'b1,  1, 1'b0, 2'b11, 4'd8, 1'b0});  // handshake edge
    tbl.push_back('{8'h99, 1'b0,  2, 1'b1, 2'b10, 4'd4, 1'b0});  // 4 presented next edge
    tbl.push_back('{8'h99, 1'b1,  4, 1'b0, 2'b10, 4'd4, 1'b0});
    tbl.push_back('{8'h00, 1'b1,  8, 1'b0, 2'b10, 4'd4, 1'b1});
    tbl.push_back('{8'h99, 1'b1,  8, 1'b0, 2'b10, 4'd4, 1'b0});  // same glyph: erro clears, no valid
    tbl.push_back('{8'h01, 1'b0,  8, 1'b1, 2'b11, 4'd8, 1'b0});  // pending word for async reset

    pool = '{8'h03, 8'h25, 8'h99, 8'h01, 8'h00, 8'hFF};

    // Reset release with 2 held: valid exactly after edge 5 (edge 0 = first edge after release).
    bus.seg_in    = 8'h25;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_word", {24'd0, dut_word()}, 32'd0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rel_vld_e%0d", i), {31'd0, bus.vel_valid}, {31'd0, (i == 5)});
      if (i == 5) chk("rel_word", {26'd0, bus.chave1, bus.chave2, bus.vel_kmh}, {26'd0, 2'b01, 4'd2});
    end

    foreach (tbl[k]) begin
      bus.seg_in    = tbl[k].seg;
      bus.out_ready = tbl[k].rdy;
      repeat (tbl[k].n) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", k), {24'd0, dut_word()},
          {24'd0, tbl[k].code, tbl[k].vel, tbl[k].vld, tbl[k].erro});
    end

    // Asynchronous reset while a word is pending, then the same glyph must be taken again.
    #2 rst_n = 1'b0;
    #1 chk("async_rst_word", {24'd0, dut_word()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rerel_vld_e%0d", i), {31'd0, bus.vel_valid}, {31'd0, (i >= 5)});
    end
    chk("rerel_word", {26'd0, bus.chave1, bus.chave2, bus.vel_kmh}, {26'd0, 2'b11, 4'd8});

    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        if ($urandom_range(0, 7) == 0) bus.seg_in = 8'($urandom);
        else                           bus.seg_in = pool[$urandom_range(0, 5)];
        hold = $urandom_range(1, 9);
      end
      hold--;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
